// File: rtl/keypad_scanner_if.sv
// Event handshake between the keypad scanner (master) and its consumer (slave).
// key_code/key_event describe the FIFO head; a transfer happens when key_valid && key_ready.
interface keypad_scanner_if #(
  parameter int KEY_W = 4
);
  logic             key_valid;
  logic             key_ready;
  logic [KEY_W-1:0] key_code;
  logic             key_event;

  modport master (
    output key_valid,
    output key_code,
    output key_event,
    input  key_ready
  );

  modport slave (
    input  key_valid,
    input  key_code,
    input  key_event,
    output key_ready
  );
endinterface

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: row drive, synchronised column sampling, frame debounce,
// press/release event generation and an event FIFO with a valid/ready head.
//
// state  | meaning
// S_IDLE | waiting for a commit whose diff is non-zero
// S_WALK | stepping through every key code, queueing the changed ones
module keypad_scanner #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int DIV_W          = 10,
  parameter int DEBOUNCE       = 3,
  parameter int FIFO_DEPTH     = 4,
  parameter bit REPORT_RELEASE = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst,
  output logic [ROWS-1:0]    line,
  input  logic [COLS-1:0]    column,
  keypad_scanner_if.master   key_if,
  output logic               held,
  output logic               overflow
);

  localparam int NKEYS   = ROWS * COLS;
  localparam int KEY_W   = $clog2(NKEYS);
  localparam int ROW_W   = $clog2(ROWS);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int STAB_W  = $clog2(DEBOUNCE + 1);
  localparam int ENTRY_W = KEY_W + 1;

  typedef enum logic {
    S_IDLE,
    S_WALK
  } walk_state_e;

  logic [COLS-1:0]    sync1_q, sync1_d;
  logic [COLS-1:0]    sync2_q, sync2_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [NKEYS-1:0]   raw_q, raw_d;
  logic [NKEYS-1:0]   prev_q, prev_d;
  logic [STAB_W-1:0]  stab_q, stab_d;
  logic [NKEYS-1:0]   deb_q, deb_d;
  logic [NKEYS-1:0]   diff_q, diff_d;
  walk_state_e        state_q, state_d;
  logic [KEY_W-1:0]   idx_q, idx_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]      wr_q, wr_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               ovf_q, ovf_d;

  logic               tick;
  logic               frame_end;
  logic [NKEYS-1:0]   frame_now;
  logic               same_frame;
  logic               commit;
  logic [NKEYS-1:0]   commit_diff;
  logic [STAB_W-1:0]  stab_inc;
  logic               push_req;
  logic               fifo_valid;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;

  always_comb begin
    sync1_d  = column;
    sync2_d  = sync1_q;
    div_d    = div_q + 1'b1;
    row_d    = row_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    stab_d   = stab_q;
    deb_d    = deb_q;
    diff_d   = diff_q;
    state_d  = state_q;
    idx_d    = idx_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;

    tick      = &div_q;
    frame_end = tick && (row_q == ROW_W'(ROWS - 1));

    // Frame as it will look once this tick's row sample lands.
    frame_now = raw_q;
    frame_now[int'(row_q) * COLS +: COLS] = sync2_q;

    same_frame  = (frame_now == prev_q);
    stab_inc    = (stab_q == STAB_W'(DEBOUNCE)) ? stab_q : stab_q + 1'b1;
    commit      = frame_end &&
                  ((DEBOUNCE == 1) || (same_frame && (int'(stab_q) + 1 >= DEBOUNCE - 1)));
    commit_diff = frame_now ^ deb_q;

    if (tick) begin
      raw_d = frame_now;
      row_d = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + 1'b1;
    end

    if (frame_end) begin
      prev_d = frame_now;
      stab_d = same_frame ? stab_inc : '0;
    end

    if (commit) begin
      deb_d  = frame_now;
      diff_d = commit_diff;
    end

    push_req = (state_q == S_WALK) && diff_q[idx_q] && (REPORT_RELEASE || deb_q[idx_q]);

    case (state_q)
      S_IDLE: begin
        if (commit && (commit_diff != '0)) begin
          state_d = S_WALK;
          idx_d   = '0;
        end
      end
      S_WALK: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == KEY_W'(NKEYS - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    fifo_valid = (cnt_q != '0);
    fifo_full  = (cnt_q == (AW + 1)'(FIFO_DEPTH));
    pop        = fifo_valid && key_if.key_ready;
    // A full FIFO still takes the push when the head leaves in the same cycle.
    push_ok    = push_req && (!fifo_full || pop);

    if (push_ok) begin
      mem_d[wr_q] = {deb_q[idx_q], idx_q};
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

    if (push_req && !push_ok) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      div_q   <= '0;
      row_q   <= '0;
      raw_q   <= '0;
      prev_q  <= '0;
      stab_q  <= '0;
      deb_q   <= '0;
      diff_q  <= '0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      div_q   <= div_d;
      row_q   <= row_d;
      raw_q   <= raw_d;
      prev_q  <= prev_d;
      stab_q  <= stab_d;
      deb_q   <= deb_d;
      diff_q  <= diff_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    mem_q <= mem_d;
  end

  always_comb begin
    line             = {{(ROWS - 1){1'b0}}, 1'b1} << row_q;
    key_if.key_valid = fifo_valid;
    key_if.key_code  = fifo_valid ? mem_q[rd_q][KEY_W-1:0] : '0;
    key_if.key_event = fifo_valid ? mem_q[rd_q][KEY_W] : 1'b0;
    held             = |deb_q;
    overflow         = ovf_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated key matrix drives two scanners (with and without
// release reporting); popped events are compared against a key-set difference model.
module tb_keypad_scanner;
  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DIV_W = 2;
  localparam int DEB   = 3;
  localparam int DEPTH = 4;
  localparam int KW    = 4;
  localparam int FRAME = ROWS * (1 << DIV_W);
  localparam int SETTLE = (DEB + 1) * FRAME + 24;

  logic clk = 1'b0;
  logic rst;
  logic [ROWS-1:0] line, line_nr;
  logic [COLS-1:0] column, column_nr;
  logic held, overflow, held_nr, overflow_nr;
  logic [15:0] keys;
  logic [15:0] model_keys;

  logic [4:0] got_q[$], exp_q[$], got_nr_q[$], exp_nr_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_scanner_if #(.KEY_W(KW)) kif ();
  keypad_scanner_if #(.KEY_W(KW)) kif_nr ();

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .DEBOUNCE(DEB),
    .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1'b1)
  ) u_dut (
    .clk_in(clk), .rst(rst), .line(line), .column(column),
    .key_if(kif.master), .held(held), .overflow(overflow)
  );

  keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .DIV_W(DIV_W), .DEBOUNCE(DEB),
    .FIFO_DEPTH(DEPTH), .REPORT_RELEASE(1'b0)
  ) u_dut_nr (
    .clk_in(clk), .rst(rst), .line(line_nr), .column(column_nr),
    .key_if(kif_nr.master), .held(held_nr), .overflow(overflow_nr)
  );

  // Key matrix: a pressed key connects its row line to its column.
  always_comb begin
    column = '0;
    for (int r = 0; r < ROWS; r++)
      if (line[r]) column = column | keys[r*COLS +: COLS];
  end

  always_comb begin
    column_nr = '0;
    for (int rn = 0; rn < ROWS; rn++)
      if (line_nr[rn]) column_nr = column_nr | keys[rn*COLS +: COLS];
  end

  always @(negedge clk) begin
    if (!rst && kif.key_valid && kif.key_ready) got_q.push_back({kif.key_event, kif.key_code});
    if (!rst && kif_nr.key_valid && kif_nr.key_ready) got_nr_q.push_back({kif_nr.key_event, kif_nr.key_code});
  end

  // Reference: every change of the stable key set yields one event per changed key, ascending code.
  task automatic set_keys(input logic [15:0] nk);
    for (int k = 0; k < 16; k++) begin
      if (model_keys[k] != nk[k]) begin
        exp_q.push_back({nk[k], 4'(k)});
        if (nk[k]) exp_nr_q.push_back({1'b1, 4'(k)});
      end
    end
    model_keys = nk;
    keys = nk;
  endtask

  task automatic clear_queues();
    got_q.delete(); exp_q.delete(); got_nr_q.delete(); exp_nr_q.delete();
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the edge where row 0 starts being driven (a frame boundary).
  task automatic align_frame();
    logic [ROWS-1:0] pl;
    bit ok;
    ok = 0;
    pl = line;
    for (int i = 0; i < 4 * FRAME; i++) begin
      @(posedge clk); #1;
      if (line == 4'b0001 && pl != 4'b0001) begin ok = 1; break; end
      pl = line;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL align_frame: no frame boundary seen, line=%b", line); end
  endtask

  task automatic test_reset();
    rst = 1'b1; keys = '0; model_keys = '0;
    kif.key_ready = 1'b1; kif_nr.key_ready = 1'b1;
    wait_cycles(3);
    rst = 1'b0;
    checks++; if (line !== 4'b0001) begin errors++; $display("FAIL reset_line: got %b want 0001", line); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", kif.key_code); end
    checks++; if (kif.key_event !== 1'b0) begin errors++; $display("FAIL reset_event: got %b want 0", kif.key_event); end
    checks++; if (held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b want 0", held); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (kif_nr.key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid_nr: got %b want 0", kif_nr.key_valid); end
  endtask

  task automatic test_single_press();
    int lat;
    clear_queues();
    align_frame();
    set_keys(16'h0200);
    // Committed at the end of the third frame that contains the key.
    wait_cycles(3 * FRAME - 1);
    checks++; if (held !== 1'b0) begin errors++; $display("FAIL single_held_early: got %b want 0", held); end
    wait_cycles(1);
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL single_held_commit: got %b want 1", held); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early: got %b want 0", kif.key_valid); end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1; lat++;
      if (kif.key_valid) break;
    end
    checks++; if (lat != 10) begin errors++; $display("FAIL single_latency: got %0d cycles want 10", lat); end
    wait_cycles(SETTLE);
    set_keys(16'h0000);
    wait_cycles(SETTLE);
    checks++; if (held !== 1'b0) begin errors++; $display("FAIL single_held_release: got %b want 0", held); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count: got %0d events want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_bounce();
    bit saw;
    clear_queues();
    saw = 0;
    align_frame();
    for (int f = 0; f < 6; f++) begin
      keys[0] = ~keys[0];
      for (int c = 0; c < FRAME; c++) begin
        @(posedge clk); #1;
        if (kif.key_valid || kif_nr.key_valid || held) saw = 1;
      end
    end
    for (int c = 0; c < SETTLE; c++) begin
      @(posedge clk); #1;
      if (kif.key_valid || kif_nr.key_valid || held) saw = 1;
    end
    checks++; if (saw) begin errors++; $display("FAIL bounce_activity: got valid/held activity want none"); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL bounce_events: got %0d want 0", got_q.size()); end
  endtask

  task automatic test_multi_keys();
    clear_queues();
    align_frame();
    set_keys(16'h1008);
    wait_cycles(SETTLE);
    checks++; if (held !== 1'b1) begin errors++; $display("FAIL multi_held: got %b want 1", held); end
    set_keys(16'h0000);
    wait_cycles(SETTLE);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL multi_count: got %0d events want 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL multi_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_no_release();
    clear_queues();
    set_keys(16'h0020);
    wait_cycles(SETTLE);
    set_keys(16'h0000);
    wait_cycles(SETTLE);
    checks++;
    if (got_nr_q.size() != 1) begin
      errors++; $display("FAIL norel_count: got %0d events want 1", got_nr_q.size());
    end else begin
      checks++;
      if (got_nr_q[0] !== 5'b1_0101) begin errors++; $display("FAIL norel_event: got %h want %h", got_nr_q[0], 5'b1_0101); end
    end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL norel_main_count: got %0d want 2", got_q.size()); end
  endtask

  task automatic test_random();
    logic [15:0] nk;
    clear_queues();
    for (int it = 0; it < 10; it++) begin
      nk = 16'($urandom & $urandom);
      align_frame();
      set_keys(nk);
      wait_cycles(SETTLE);
      checks++; if (held !== (|nk)) begin errors++; $display("FAIL rand_held[%0d]: got %b want %b", it, held, |nk); end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++;
    if (got_nr_q.size() != exp_nr_q.size()) begin
      errors++; $display("FAIL rand_nr_count: got %0d want %0d", got_nr_q.size(), exp_nr_q.size());
    end else begin
      for (int i = 0; i < exp_nr_q.size(); i++) begin
        checks++;
        if (got_nr_q[i] !== exp_nr_q[i]) begin errors++; $display("FAIL rand_nr_event[%0d]: got %h want %h", i, got_nr_q[i], exp_nr_q[i]); end
      end
    end
  endtask

  task automatic test_overflow();
    set_keys(16'h0000);
    wait_cycles(SETTLE);
    clear_queues();
    kif.key_ready = 1'b0;
    align_frame();
    set_keys(16'h4446);
    wait_cycles(SETTLE);
    // Only the first DEPTH events fit while nothing drains.
    while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    checks++; if (kif.key_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid: got %b want 1", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd1) begin errors++; $display("FAIL ovf_head: got %0d want 1", kif.key_code); end
    wait_cycles(5);
    checks++; if ({kif.key_event, kif.key_code} !== 5'b1_0001) begin errors++; $display("FAIL ovf_head_stable: got %h want 11", {kif.key_event, kif.key_code}); end
    kif.key_ready = 1'b1;
    wait_cycles(8);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_count: got %0d want %0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %b want 0", kif.key_valid); end
    checks++; if (kif.key_code !== 4'd0 || kif.key_event !== 1'b0) begin errors++; $display("FAIL ovf_empty_head: got %h want 0", {kif.key_event, kif.key_code}); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    checks++; if (overflow_nr !== 1'b0) begin errors++; $display("FAIL ovf_nr_flag: got %b want 0", overflow_nr); end
    checks++; if (got_nr_q.size() != 5) begin errors++; $display("FAIL ovf_nr_count: got %0d want 5", got_nr_q.size()); end
  endtask

  task automatic test_reset_midwalk();
    set_keys(16'h0000);
    wait_cycles(SETTLE);
    clear_queues();
    align_frame();
    set_keys(16'h8001);
    repeat (3 * FRAME) @(posedge clk);
    #1;
    rst = 1'b1;
    wait_cycles(1);
    rst = 1'b0;
    model_keys = '0;
    clear_queues();
    checks++; if (line !== 4'b0001) begin errors++; $display("FAIL rstwalk_line: got %b want 0001", line); end
    checks++; if (kif.key_valid !== 1'b0) begin errors++; $display("FAIL rstwalk_valid: got %b want 0", kif.key_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstwalk_overflow: got %b want 0", overflow); end
    checks++; if (held !== 1'b0) begin errors++; $display("FAIL rstwalk_held: got %b want 0", held); end
    set_keys(keys);
    wait_cycles(SETTLE);
    checks++;
    if (got_q.size() != 2) begin
      errors++; $display("FAIL rstwalk_count: got %0d events want 2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstwalk_event[%0d]: got %h want %h", i, got_q[i], exp_q[i]); end
      end
    end
    checks++; if (got_nr_q.size() != 2) begin errors++; $display("FAIL rstwalk_nr_count: got %0d want 2", got_nr_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_keys();
    test_no_release();
    test_random();
    test_overflow();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end
endmodule
